// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: card/PIN entry sequencer with retry limit, inactivity timeout and card retention
module pin_entry_ctrl #(
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  card_acc_num,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        clear,
  input  logic        cancel,
  input  logic        session_end,
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [2:0]  digit_cnt,
  output logic [1:0]  tries_left,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic        acc_unknown,
  output logic        session_active,
  output logic        card_eject,
  output logic        card_retained
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANTED, LOCKED} state_t;
  state_t state, state_n;
  logic [3:0] acc_num_n;
  logic [15:0] pin_n;
  logic [2:0] digit_cnt_n;
  logic [1:0] tries_n;
  logic [TW-1:0] timer, timer_n;
  logic auth_ok_n, auth_fail_n, acc_unknown_n, card_eject_n, card_retained_n;
  logic [16:0] pin_mac;
  logic digit_ok;
  assign pin_mac = 17'(pin) * 17'd10 + 17'(digit);
  assign digit_ok = digit_valid && digit <= 4'd9 && digit_cnt < 3'd4;
  always_comb begin
    state_n = state;
    acc_num_n = acc_num;
    pin_n = pin;
    digit_cnt_n = digit_cnt;
    tries_n = tries_left;
    timer_n = '0;
    auth_ok_n = 1'b0;
    auth_fail_n = 1'b0;
    acc_unknown_n = 1'b0;
    card_eject_n = 1'b0;
    card_retained_n = card_retained;
    case (state)
      IDLE: if (card_in) begin
        state_n = ENTRY;
        acc_num_n = card_acc_num;
        pin_n = '0;
        digit_cnt_n = '0;
        tries_n = 2'(MAX_TRIES);
      end
      ENTRY: if (cancel || (!clear && !enter && !digit_ok && timer == TW'(TIMEOUT_CYCLES - 1))) begin
        state_n = IDLE;
        card_eject_n = 1'b1;
        pin_n = '0;
        digit_cnt_n = '0;
      end else if (clear) begin
        pin_n = '0;
        digit_cnt_n = '0;
      end else if (enter) begin
        state_n = digit_cnt == 3'd4 ? CHECK : ENTRY;
      end else if (digit_ok) begin
        pin_n = pin_mac[15:0];
        digit_cnt_n = digit_cnt + 3'd1;
      end else begin
        timer_n = timer + 1'b1;
      end
      CHECK: if (!acc_found_stat) begin
        state_n = IDLE;
        acc_unknown_n = 1'b1;
        card_eject_n = 1'b1;
        pin_n = '0;
        digit_cnt_n = '0;
      end else if (acc_auth_stat) begin
        state_n = GRANTED;
        auth_ok_n = 1'b1;
      end else begin
        tries_n = tries_left - 2'd1;
        pin_n = '0;
        digit_cnt_n = '0;
        state_n = tries_left == 2'd1 ? LOCKED : ENTRY;
        auth_fail_n = tries_left != 2'd1;
        card_retained_n = tries_left == 2'd1;
      end
      GRANTED: if (session_end || cancel) begin
        state_n = IDLE;
        card_eject_n = 1'b1;
        pin_n = '0;
        digit_cnt_n = '0;
      end
      LOCKED: state_n = LOCKED;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc_num <= '0;
      pin <= '0;
      digit_cnt <= '0;
      tries_left <= '0;
      timer <= '0;
      auth_ok <= 1'b0;
      auth_fail <= 1'b0;
      acc_unknown <= 1'b0;
      session_active <= 1'b0;
      card_eject <= 1'b0;
      card_retained <= 1'b0;
    end else begin
      state <= state_n;
      acc_num <= acc_num_n;
      pin <= pin_n;
      digit_cnt <= digit_cnt_n;
      tries_left <= tries_n;
      timer <= timer_n;
      auth_ok <= auth_ok_n;
      auth_fail <= auth_fail_n;
      acc_unknown <= acc_unknown_n;
      session_active <= state_n == GRANTED;
      card_eject <= card_eject_n;
      card_retained <= card_retained_n;
    end
  end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: directed scenarios for pin_entry_ctrl
module tb_pin_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic card_in = 1'b0, digit_valid = 1'b0, enter = 1'b0, clear = 1'b0, cancel = 1'b0, session_end = 1'b0;
  logic acc_found_stat = 1'b0, acc_auth_stat = 1'b0;
  logic [3:0] card_acc_num = '0, digit = '0;
  logic [3:0] acc_num;
  logic [15:0] pin;
  logic [2:0] digit_cnt;
  logic [1:0] tries_left;
  logic auth_ok, auth_fail, acc_unknown, session_active, card_eject, card_retained;
  int checks = 0;
  int errors = 0;
  pin_entry_ctrl #(.MAX_TRIES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_acc_num(card_acc_num),
    .digit_valid(digit_valid), .digit(digit), .enter(enter), .clear(clear),
    .cancel(cancel), .session_end(session_end), .acc_found_stat(acc_found_stat),
    .acc_auth_stat(acc_auth_stat), .acc_num(acc_num), .pin(pin), .digit_cnt(digit_cnt),
    .tries_left(tries_left), .auth_ok(auth_ok), .auth_fail(auth_fail),
    .acc_unknown(acc_unknown), .session_active(session_active),
    .card_eject(card_eject), .card_retained(card_retained)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic insert(input logic [3:0] a);
    card_in = 1'b1;
    card_acc_num = a;
    tick();
    card_in = 1'b0;
  endtask
  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
  endtask
  task automatic submit();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if ({acc_num, pin, digit_cnt, tries_left} !== 25'd0) begin errors++; $display("FAIL reset_regs: got acc=%0d pin=%0d cnt=%0d tries=%0d expected all 0", acc_num, pin, digit_cnt, tries_left); end
    checks++; if ({auth_ok, auth_fail, acc_unknown, session_active, card_eject, card_retained} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {auth_ok, auth_fail, acc_unknown, session_active, card_eject, card_retained}); end
  endtask
  task automatic test_auth_ok();
    insert(4'd5);
    checks++; if (acc_num !== 4'd5 || tries_left !== 2'd3 || digit_cnt !== 3'd0) begin errors++; $display("FAIL insert: got acc=%0d tries=%0d cnt=%0d expected 5 3 0", acc_num, tries_left, digit_cnt); end
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    checks++; if (pin !== 16'd1234 || digit_cnt !== 3'd4) begin errors++; $display("FAIL entry_pin: got pin=%0d cnt=%0d expected 1234 4", pin, digit_cnt); end
    acc_found_stat = 1'b1;
    acc_auth_stat = 1'b1;
    submit();
    checks++; if (pin !== 16'd1234 || auth_ok !== 1'b0) begin errors++; $display("FAIL check_pin: got pin=%0d auth_ok=%b expected 1234 0", pin, auth_ok); end
    tick();
    checks++; if (auth_ok !== 1'b1 || session_active !== 1'b1) begin errors++; $display("FAIL grant: got auth_ok=%b active=%b expected 1 1", auth_ok, session_active); end
    tick();
    checks++; if (auth_ok !== 1'b0 || session_active !== 1'b1 || pin !== 16'd1234) begin errors++; $display("FAIL grant_hold: got auth_ok=%b active=%b pin=%0d expected 0 1 1234", auth_ok, session_active, pin); end
    session_end = 1'b1;
    tick();
    session_end = 1'b0;
    checks++; if (card_eject !== 1'b1 || session_active !== 1'b0 || pin !== 16'd0) begin errors++; $display("FAIL session_end: got eject=%b active=%b pin=%0d expected 1 0 0", card_eject, session_active, pin); end
    tick();
    checks++; if (card_eject !== 1'b0) begin errors++; $display("FAIL eject_pulse: got %b expected 0", card_eject); end
  endtask
  task automatic test_lockout();
    insert(4'd3);
    acc_found_stat = 1'b1;
    acc_auth_stat = 1'b0;
    for (int r = 0; r < 3; r++) begin
      key(4'd1); key(4'd1); key(4'd1); key(4'd1);
      submit();
      tick();
      checks++; if (tries_left !== 2'(2 - r) || auth_fail !== (r < 2) || card_eject !== 1'b0) begin errors++; $display("FAIL lock_round%0d: got tries=%0d fail=%b eject=%b expected %0d %b 0", r, tries_left, auth_fail, card_eject, 2 - r, r < 2); end
      checks++; if (pin !== 16'd0 || digit_cnt !== 3'd0 || card_retained !== (r == 2)) begin errors++; $display("FAIL lock_state%0d: got pin=%0d cnt=%0d retained=%b expected 0 0 %b", r, pin, digit_cnt, card_retained, r == 2); end
    end
    card_in = 1'b1; cancel = 1'b1; session_end = 1'b1; digit_valid = 1'b1; digit = 4'd7; card_acc_num = 4'd9;
    tick();
    tick();
    card_in = 1'b0; cancel = 1'b0; session_end = 1'b0; digit_valid = 1'b0;
    checks++; if (card_retained !== 1'b1 || card_eject !== 1'b0 || pin !== 16'd0 || acc_num !== 4'd3) begin errors++; $display("FAIL locked_hold: got retained=%b eject=%b pin=%0d acc=%0d expected 1 0 0 3", card_retained, card_eject, pin, acc_num); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (card_retained !== 1'b0 || card_eject !== 1'b0 || tries_left !== 2'd0) begin errors++; $display("FAIL locked_reset: got retained=%b eject=%b tries=%0d expected 0 0 0", card_retained, card_eject, tries_left); end
  endtask
  task automatic test_clear_overflow();
    insert(4'd6);
    key(4'd9); key(4'd8);
    checks++; if (pin !== 16'd98 || digit_cnt !== 3'd2) begin errors++; $display("FAIL pre_clear: got pin=%0d cnt=%0d expected 98 2", pin, digit_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (pin !== 16'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL clear: got pin=%0d cnt=%0d expected 0 0", pin, digit_cnt); end
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    checks++; if (pin !== 16'd1234 || digit_cnt !== 3'd4) begin errors++; $display("FAIL fifth_digit: got pin=%0d cnt=%0d expected 1234 4", pin, digit_cnt); end
    insert(4'd2);
    checks++; if (acc_num !== 4'd6 || pin !== 16'd1234) begin errors++; $display("FAIL card_in_entry: got acc=%0d pin=%0d expected 6 1234", acc_num, pin); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    key(4'd1); key(4'd2); key(4'd3);
    acc_found_stat = 1'b0;
    submit();
    tick();
    checks++; if (acc_unknown !== 1'b0 || card_eject !== 1'b0 || pin !== 16'd123 || digit_cnt !== 3'd3) begin errors++; $display("FAIL short_enter: got unk=%b eject=%b pin=%0d cnt=%0d expected 0 0 123 3", acc_unknown, card_eject, pin, digit_cnt); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (card_eject !== 1'b1 || pin !== 16'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL cancel: got eject=%b pin=%0d cnt=%0d expected 1 0 0", card_eject, pin, digit_cnt); end
  endtask
  task automatic test_unknown();
    insert(4'd7);
    key(4'd12);
    checks++; if (pin !== 16'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL digit12: got pin=%0d cnt=%0d expected 0 0", pin, digit_cnt); end
    key(4'd4); key(4'd3); key(4'd2); key(4'd1);
    acc_found_stat = 1'b0;
    submit();
    tick();
    checks++; if (acc_unknown !== 1'b1 || card_eject !== 1'b1 || pin !== 16'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL unknown: got unk=%b eject=%b pin=%0d cnt=%0d expected 1 1 0 0", acc_unknown, card_eject, pin, digit_cnt); end
    tick();
    checks++; if (acc_unknown !== 1'b0 || card_eject !== 1'b0) begin errors++; $display("FAIL unknown_pulse: got unk=%b eject=%b expected 0 0", acc_unknown, card_eject); end
  endtask
  task automatic test_timeout();
    insert(4'd1);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (card_eject !== 1'b0) begin errors++; $display("FAIL timeout_early: got eject=%b expected 0", card_eject); end
    tick();
    checks++; if (card_eject !== 1'b1) begin errors++; $display("FAIL timeout: got eject=%b expected 1", card_eject); end
    key(4'd5);
    checks++; if (digit_cnt !== 3'd0 || card_eject !== 1'b0) begin errors++; $display("FAIL idle_digit: got cnt=%0d eject=%b expected 0 0", digit_cnt, card_eject); end
    insert(4'd2);
    cancel = 1'b1; digit_valid = 1'b1; digit = 4'd3;
    tick();
    cancel = 1'b0; digit_valid = 1'b0;
    checks++; if (card_eject !== 1'b1 || pin !== 16'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL cancel_wins: got eject=%b pin=%0d cnt=%0d expected 1 0 0", card_eject, pin, digit_cnt); end
  endtask
  task automatic test_reset_granted();
    insert(4'd8);
    key(4'd2); key(4'd0); key(4'd2); key(4'd5);
    acc_found_stat = 1'b1;
    acc_auth_stat = 1'b1;
    submit();
    tick();
    checks++; if (session_active !== 1'b1 || pin !== 16'd2025) begin errors++; $display("FAIL grant2: got active=%b pin=%0d expected 1 2025", session_active, pin); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({acc_num, pin, digit_cnt, tries_left} !== 25'd0 || {auth_ok, auth_fail, acc_unknown, session_active, card_eject, card_retained} !== 6'b0) begin errors++; $display("FAIL grant_reset: got acc=%0d pin=%0d cnt=%0d tries=%0d flags=%b expected all 0", acc_num, pin, digit_cnt, tries_left, {auth_ok, auth_fail, acc_unknown, session_active, card_eject, card_retained}); end
    insert(4'd9);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    checks++; if (acc_num !== 4'd9 || tries_left !== 2'd3 || pin !== 16'd5678 || session_active !== 1'b0) begin errors++; $display("FAIL fresh: got acc=%0d tries=%0d pin=%0d active=%b expected 9 3 5678 0", acc_num, tries_left, pin, session_active); end
  endtask
  initial begin
    test_reset();
    test_auth_ok();
    test_lockout();
    test_clear_overflow();
    test_unknown();
    test_timeout();
    test_reset_granted();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
